// File: rtl/dmac_master_arbiter.sv
// -----------------------------------------------------------------------------
// dmac_master_arbiter
//
// Shares one AHB master port between NUM_CH DMA channels. Ownership is handed
// out round-robin, one burst at a time. A drain phase sits between owners so
// the outgoing owner's last data phase finishes before anyone else drives an
// address phase.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   ch_req         per-channel bus request; the owner holds it for its burst
//   ch_htrans      per-channel HTRANS, slice [2i+1:2i]
//   ch_write       per-channel HWRITE
//   ch_addr        per-channel address, slice [32i+31:32i]
//   ch_wdata       per-channel write data, slice [32i+31:32i]
//   ch_wstrb       per-channel write strobes, slice [4i+3:4i]
//   ch_burst       per-channel HBURST, slice [3i+2:3i]
//   ch_ready       HREADY returned to the owner only
//   ch_hresp       HRESP returned to the owner only (others see 2'b00)
//   ch_grant       registered one-hot grant
//   m_htrans ..    muxed bus address/control/data toward the slave side
//   m_hready       bus HREADY
//   m_hresp        bus HRESP
//   busy           arbiter is not idle
//   owner_id       index of the current or draining owner
// -----------------------------------------------------------------------------
module dmac_master_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      ch_req,
    input  logic [2*NUM_CH-1:0]    ch_htrans,
    input  logic [NUM_CH-1:0]      ch_write,
    input  logic [32*NUM_CH-1:0]   ch_addr,
    input  logic [32*NUM_CH-1:0]   ch_wdata,
    input  logic [4*NUM_CH-1:0]    ch_wstrb,
    input  logic [3*NUM_CH-1:0]    ch_burst,
    output logic [NUM_CH-1:0]      ch_ready,
    output logic [2*NUM_CH-1:0]    ch_hresp,
    output logic [NUM_CH-1:0]      ch_grant,
    output logic [1:0]             m_htrans,
    output logic                   m_write,
    output logic [31:0]            m_haddr,
    output logic [31:0]            m_hwdata,
    output logic [3:0]             m_hwstrb,
    output logic [2:0]             m_hburst,
    input  logic                   m_hready,
    input  logic [1:0]             m_hresp,
    output logic                   busy,
    output logic [IDX_W-1:0]       owner_id
);

    localparam int unsigned NCH = NUM_CH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    logic [NUM_CH-1:0]  r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic               w_any_req;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic               w_owner_req;

    logic [1:0]         w_htrans_a [NUM_CH];
    logic               w_write_a  [NUM_CH];
    logic [31:0]        w_addr_a   [NUM_CH];
    logic [31:0]        w_wdata_a  [NUM_CH];
    logic [3:0]         w_wstrb_a  [NUM_CH];
    logic [2:0]         w_burst_a  [NUM_CH];

    // (base + off) mod NUM_CH, with off < NUM_CH
    function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base,
                                                     input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_CH-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Unpack the per-channel buses once so the owner mux is a plain index.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_htrans_a[g] = ch_htrans[2*g +: 2];
        assign w_write_a[g]  = ch_write[g];
        assign w_addr_a[g]   = ch_addr[32*g +: 32];
        assign w_wdata_a[g]  = ch_wdata[32*g +: 32];
        assign w_wstrb_a[g]  = ch_wstrb[4*g +: 4];
        assign w_burst_a[g]  = ch_burst[3*g +: 3];
    end

    assign w_any_req   = |ch_req;
    assign w_owner_req = ch_req[r_owner];

    // Round-robin pick: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!w_found && ch_req[f_wrap_add(r_rr_ptr, i)]) begin
                w_found  = 1'b1;
                w_winner = f_wrap_add(r_rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_winner;
                        r_grant <= f_onehot(w_winner);
                    end
                end
                ST_GRANT: begin
                    // Release only once the owner's final beat is accepted;
                    // other requests never preempt a held grant.
                    if (!w_owner_req && m_hready) begin
                        r_state  <= ST_DRAIN;
                        r_grant  <= '0;
                        r_rr_ptr <= f_wrap_add(r_owner, 1);
                    end
                end
                ST_DRAIN: begin
                    // r_rr_ptr was already advanced on entry, so the winner
                    // here starts after the outgoing owner.
                    if (m_hready) begin
                        if (w_any_req) begin
                            r_state <= ST_GRANT;
                            r_owner <= w_winner;
                            r_grant <= f_onehot(w_winner);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Bus mux. During drain the address phase is forced IDLE while the data
    // phase signals stay on the outgoing owner.
    always_comb begin
        m_htrans = '0;
        m_write  = 1'b0;
        m_haddr  = '0;
        m_hwdata = '0;
        m_hwstrb = '0;
        m_hburst = '0;
        case (r_state)
            ST_GRANT: begin
                m_htrans = w_htrans_a[r_owner];
                m_write  = w_write_a[r_owner];
                m_haddr  = w_addr_a[r_owner];
                m_hwdata = w_wdata_a[r_owner];
                m_hwstrb = w_wstrb_a[r_owner];
                m_hburst = w_burst_a[r_owner];
            end
            ST_DRAIN: begin
                m_haddr  = w_addr_a[r_owner];
                m_hwdata = w_wdata_a[r_owner];
                m_hwstrb = w_wstrb_a[r_owner];
                m_hburst = w_burst_a[r_owner];
            end
            default: begin
            end
        endcase
    end

    // Response routing: only the current/draining owner sees HREADY/HRESP.
    always_comb begin
        ch_ready = '0;
        ch_hresp = '0;
        if (r_state != ST_IDLE) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (i == 32'(r_owner)) begin
                    ch_ready[i]       = m_hready;
                    ch_hresp[2*i +: 2] = m_hresp;
                end
            end
        end
    end

    assign ch_grant = r_grant;
    assign owner_id = r_owner;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmac_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmac_master_arbiter
//
// Each record holds one cycle of inputs and the outputs expected right after
// the following clock edge. Records are queued when their inputs are driven
// and popped and compared 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_dmac_master_arbiter;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_req;
    logic [3:0]  ch_htrans;
    logic [1:0]  ch_write;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [7:0]  ch_wstrb;
    logic [5:0]  ch_burst;
    logic [1:0]  ch_ready;
    logic [3:0]  ch_hresp;
    logic [1:0]  ch_grant;
    logic [1:0]  m_htrans;
    logic        m_write;
    logic [31:0] m_haddr;
    logic [31:0] m_hwdata;
    logic [3:0]  m_hwstrb;
    logic [2:0]  m_hburst;
    logic        m_hready;
    logic [1:0]  m_hresp;
    logic        busy;
    logic [0:0]  owner_id;

    dmac_master_arbiter #(.NUM_CH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_req    (ch_req),
        .ch_htrans (ch_htrans),
        .ch_write  (ch_write),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_wstrb  (ch_wstrb),
        .ch_burst  (ch_burst),
        .ch_ready  (ch_ready),
        .ch_hresp  (ch_hresp),
        .ch_grant  (ch_grant),
        .m_htrans  (m_htrans),
        .m_write   (m_write),
        .m_haddr   (m_haddr),
        .m_hwdata  (m_hwdata),
        .m_hwstrb  (m_hwstrb),
        .m_hburst  (m_hburst),
        .m_hready  (m_hready),
        .m_hresp   (m_hresp),
        .busy      (busy),
        .owner_id  (owner_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  req;
        logic [3:0]  htr;
        logic        rdy;
        logic [1:0]  resp;
        logic [1:0]  e_grant;
        logic [1:0]  e_htrans;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_ready;
        logic [3:0]  e_hresp;
        logic        e_busy;
        logic        e_owner;
    } vec_t;

    vec_t tbl [22];
    vec_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input string n, input logic r, input logic [1:0] q,
                                input logic [3:0] h, input logic y, input logic [1:0] s,
                                input logic [1:0] g, input logic [1:0] t,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] rd, input logic [3:0] hr,
                                input logic b, input logic o);
        vec_t v;
        v.name = n;     v.rst = r;      v.req = q;      v.htr = h;
        v.rdy = y;      v.resp = s;     v.e_grant = g;  v.e_htrans = t;
        v.e_addr = a;   v.e_wdata = d;  v.e_ready = rd; v.e_hresp = hr;
        v.e_busy = b;   v.e_owner = o;
        return v;
    endfunction

    task automatic check_front();
        vec_t e;
        e = exp_q.pop_front();
        checks++;
        if ({ch_grant, m_htrans, m_haddr, m_hwdata, ch_ready, ch_hresp, busy, owner_id} !==
            {e.e_grant, e.e_htrans, e.e_addr, e.e_wdata, e.e_ready, e.e_hresp, e.e_busy, e.e_owner}) begin
            failures++;
            $display("FAIL %s: got grant=%b htrans=%b addr=%h wdata=%h ready=%b hresp=%b busy=%b owner=%0d, expected grant=%b htrans=%b addr=%h wdata=%h ready=%b hresp=%b busy=%b owner=%0d",
                     e.name, ch_grant, m_htrans, m_haddr, m_hwdata, ch_ready, ch_hresp, busy, owner_id,
                     e.e_grant, e.e_htrans, e.e_addr, e.e_wdata, e.e_ready, e.e_hresp, e.e_busy, e.e_owner);
        end
    endtask

    task automatic apply(input vec_t v);
        rst       = v.rst;
        ch_req    = v.req;
        ch_htrans = v.htr;
        m_hready  = v.rdy;
        m_hresp   = v.resp;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        rst       = 1'b1;
        ch_req    = '0;
        ch_htrans = '0;
        ch_write  = 2'b01;
        ch_addr   = {A1, A0};
        ch_wdata  = {D1, D0};
        ch_wstrb  = {4'hC, 4'h3};
        ch_burst  = {3'd1, 3'd3};
        m_hready  = 1'b1;
        m_hresp   = 2'b00;

        //            name               rst req    htr      rdy resp    grant  htrans  addr D     ready  hresp busy own
        tbl[0]  = mk("reset",            1, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, '0, '0, 2'b00, 4'h0, 0, 0);
        tbl[1]  = mk("t1_grant",         0, 2'b01, 4'b0010, 1, 2'b00,  2'b01, 2'b10, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[2]  = mk("t1_hold",          0, 2'b01, 4'b0011, 1, 2'b00,  2'b01, 2'b11, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[3]  = mk("t1_drain",         0, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[4]  = mk("t1_idle",          0, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, '0, '0, 2'b00, 4'h0, 0, 0);
        tbl[5]  = mk("t2_reset",         1, 2'b11, 4'b1010, 1, 2'b00,  2'b00, 2'b00, '0, '0, 2'b00, 4'h0, 0, 0);
        tbl[6]  = mk("t2_ch0_first",     0, 2'b11, 4'b1010, 1, 2'b00,  2'b01, 2'b10, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[7]  = mk("t2_drain",         0, 2'b10, 4'b1000, 1, 2'b00,  2'b00, 2'b00, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[8]  = mk("t2_ch1",           0, 2'b10, 4'b1000, 1, 2'b00,  2'b10, 2'b10, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[9]  = mk("t3_no_preempt",    0, 2'b11, 4'b1010, 1, 2'b00,  2'b10, 2'b10, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[10] = mk("t3_drain1",        0, 2'b01, 4'b0010, 1, 2'b00,  2'b00, 2'b00, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[11] = mk("t3_wrap_ch0",      0, 2'b11, 4'b1010, 1, 2'b00,  2'b01, 2'b10, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[12] = mk("alt_drain0",       0, 2'b10, 4'b1000, 1, 2'b00,  2'b00, 2'b00, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[13] = mk("alt_ch1",          0, 2'b11, 4'b1010, 1, 2'b00,  2'b10, 2'b10, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[14] = mk("alt_drain1",       0, 2'b01, 4'b0010, 1, 2'b00,  2'b00, 2'b00, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[15] = mk("alt_ch0",          0, 2'b11, 4'b1010, 1, 2'b00,  2'b01, 2'b10, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[16] = mk("rel_drain0",       0, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, A0, D0, 2'b01, 4'h0, 1, 0);
        tbl[17] = mk("rel_idle",         0, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, '0, '0, 2'b00, 4'h0, 0, 0);
        tbl[18] = mk("solo_ch1",         0, 2'b10, 4'b1000, 1, 2'b00,  2'b10, 2'b10, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[19] = mk("rel_wait_hready",  0, 2'b00, 4'b0000, 0, 2'b00,  2'b10, 2'b00, A1, D1, 2'b00, 4'h0, 1, 1);
        tbl[20] = mk("rel_drain1",       0, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, A1, D1, 2'b10, 4'h0, 1, 1);
        tbl[21] = mk("rel_idle1",        0, 2'b00, 4'b0000, 1, 2'b00,  2'b00, 2'b00, '0, '0, 2'b00, 4'h0, 0, 1);

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i]);
        end

        // Drain stretched by HREADY low: data phase stays on ch1, no grant.
        apply(mk("t4_grant1",  0, 2'b10, 4'b1000, 1, 2'b00, 2'b10, 2'b10, A1, D1, 2'b10, 4'h0, 1, 1));
        apply(mk("t4_drain",   0, 2'b00, 4'b0000, 1, 2'b00, 2'b00, 2'b00, A1, D1, 2'b10, 4'h0, 1, 1));
        for (int k = 0; k < 3; k++) begin
            apply(mk($sformatf("t4_drain_hold%0d", k),
                     0, 2'b01, 4'b0010, 0, 2'b00, 2'b00, 2'b00, A1, D1, 2'b00, 4'h0, 1, 1));
        end
        apply(mk("t4_grant_after_ready", 0, 2'b01, 4'b0010, 1, 2'b00, 2'b01, 2'b10, A0, D0, 2'b01, 4'h0, 1, 0));

        // ERROR response routed to ch0 only; grant held while ch0 requests.
        apply(mk("t5_err_route",  0, 2'b01, 4'b0011, 1, 2'b01, 2'b01, 2'b11, A0, D0, 2'b01, 4'b0001, 1, 0));
        apply(mk("t5_err_wait",   0, 2'b11, 4'b1000, 0, 2'b01, 2'b01, 2'b00, A0, D0, 2'b00, 4'b0001, 1, 0));
        apply(mk("t5_err_held",   0, 2'b11, 4'b1000, 1, 2'b01, 2'b01, 2'b00, A0, D0, 2'b01, 4'b0001, 1, 0));

        // Reset while ch1 owns the bus: rr pointer must return to ch0.
        apply(mk("t6_drain0",     0, 2'b10, 4'b1000, 1, 2'b00, 2'b00, 2'b00, A0, D0, 2'b01, 4'h0, 1, 0));
        apply(mk("t6_grant1",     0, 2'b10, 4'b1000, 1, 2'b00, 2'b10, 2'b10, A1, D1, 2'b10, 4'h0, 1, 1));
        apply(mk("t6_reset",      1, 2'b11, 4'b1010, 1, 2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 4'h0, 0, 0));
        apply(mk("t6_ch0_after",  0, 2'b11, 4'b1010, 1, 2'b00, 2'b01, 2'b10, A0, D0, 2'b01, 4'h0, 1, 0));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
